// File: rtl/counter_monitor.sv
// Sequence monitor for a free-running counter bus: checks START after reset, then +1 steps,
// and reports lock, one-cycle error pulses with expected/observed values, and saturating counters.
module counter_monitor #(
  parameter int WIDTH    = 4,
  parameter int START    = 0,
  parameter int LOCK_LEN = 2,
  parameter int CW       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  output logic             locked,
  output logic             err,
  output logic [CW-1:0]    err_count,
  output logic [CW-1:0]    wrap_count,
  output logic [WIDTH-1:0] exp_val,
  output logic [WIDTH-1:0] bad_val
);

  localparam int               GW      = $clog2(LOCK_LEN + 1);
  localparam logic [WIDTH-1:0] START_V = WIDTH'(START);
  localparam logic [GW-1:0]    LOCK_V  = GW'(LOCK_LEN);

  typedef enum logic [1:0] {IDLE, TRACK, SYNC} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [GW-1:0]    good_q, good_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [CW-1:0]    ec_q, ec_d;
  logic [CW-1:0]    wc_q, wc_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] bad_q, bad_d;

  logic [WIDTH-1:0] nxt;
  logic [GW-1:0]    good_inc;
  logic             hit, relock;

  assign nxt      = prev_q + WIDTH'(1);
  assign hit      = (a == nxt);
  assign good_inc = good_q + GW'(1);
  assign relock   = hit && (good_inc == LOCK_V);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      good_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      ec_q     <= '0;
      wc_q     <= '0;
      exp_q    <= '0;
      bad_q    <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      good_q   <= good_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      ec_q     <= ec_d;
      wc_q     <= wc_d;
      exp_q    <= exp_d;
      bad_q    <= bad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (a == START_V) ? TRACK : SYNC;
      TRACK:   if (!hit) state_d = SYNC;
      SYNC:    if (relock) state_d = TRACK;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prev_d   = a;
    good_d   = good_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    wc_d     = wc_q;
    exp_d    = exp_q;
    bad_d    = bad_q;
    case (state_q)
      IDLE: begin
        if (a == START_V) begin
          locked_d = 1'b1;
        end else begin
          err_d  = 1'b1;
          exp_d  = START_V;
          bad_d  = a;
          good_d = '0;
        end
      end
      TRACK: begin
        // a hit from all-ones can only be a wrap to zero
        if (hit) begin
          if (prev_q == '1 && wc_q != '1) wc_d = wc_q + CW'(1);
        end else begin
          err_d    = 1'b1;
          exp_d    = nxt;
          bad_d    = a;
          locked_d = 1'b0;
          good_d   = '0;
        end
      end
      SYNC: begin
        if (relock) begin
          locked_d = 1'b1;
          good_d   = '0;
        end else if (hit) begin
          good_d = good_inc;
        end else begin
          good_d = '0;
        end
      end
      default: good_d = '0;
    endcase
    ec_d = (err_d && ec_q != '1) ? ec_q + CW'(1) : ec_q;
  end

  assign locked     = locked_q;
  assign err        = err_q;
  assign err_count  = ec_q;
  assign wrap_count = wc_q;
  assign exp_val    = exp_q;
  assign bad_val    = bad_q;

endmodule
